// File: rtl/queue_pkg.sv
// Shared types and default sizing for the queue controller.
// Stats outputs (servedCount, peakCount) exist only with QUEUE_STATS_EN.
package queue_pkg;

    localparam int DEF_MAX_PEOPLE  = 7;
    localparam int DEF_MAX_TELLERS = 3;
    localparam int DEF_SERVICE_T   = 3;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } q_state_t;

endpackage

// File: rtl/queue_if.sv
// Sensor, teller and status bundle between the queue controller and its user.
// Stats signals are present only with QUEUE_STATS_EN.
interface queue_if
    import queue_pkg::*;
#(
    parameter int MAX_PEOPLE  = DEF_MAX_PEOPLE,
    parameter int MAX_TELLERS = DEF_MAX_TELLERS,
    parameter int SERVICE_T   = DEF_SERVICE_T
);
    localparam int PW = $clog2(MAX_PEOPLE + 1);
    localparam int TW = $clog2(MAX_TELLERS + 1);
    localparam int WW = $clog2(SERVICE_T * MAX_PEOPLE + 1);

    logic          upSignal;
    logic          downSignal;
    logic [TW-1:0] Tcount;
    logic [PW-1:0] Pcount;
    logic [WW-1:0] Wtime;
    logic          fullFlag;
    logic          emptyFlag;
    logic          ovfErr;
    logic          udfErr;
    logic          tellerErr;
`ifdef QUEUE_STATS_EN
    logic [15:0]   servedCount;
    logic [PW-1:0] peakCount;

    modport master (
        output upSignal, downSignal, Tcount,
        input  Pcount, Wtime, fullFlag, emptyFlag,
        input  ovfErr, udfErr, tellerErr,
        input  servedCount, peakCount
    );
    modport slave (
        input  upSignal, downSignal, Tcount,
        output Pcount, Wtime, fullFlag, emptyFlag,
        output ovfErr, udfErr, tellerErr,
        output servedCount, peakCount
    );
`else
    modport master (
        output upSignal, downSignal, Tcount,
        input  Pcount, Wtime, fullFlag, emptyFlag,
        input  ovfErr, udfErr, tellerErr
    );
    modport slave (
        input  upSignal, downSignal, Tcount,
        output Pcount, Wtime, fullFlag, emptyFlag,
        output ovfErr, udfErr, tellerErr
    );
`endif

endinterface

// File: rtl/sensor_edge.sv
// Two-flop synchronizer plus registered rising-edge detector.
// A level already high when reset releases never produces a pulse.
module sensor_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic       s1;
    logic       s2;
    logic       prev;
    logic [2:0] arm;

    // arm fills only once s2/prev hold real samples of din
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            arm   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            prev  <= s2;
            arm   <= {arm[1:0], 1'b1};
            pulse <= s2 & ~prev & arm[2];
        end
    end

endmodule

// File: rtl/queue_ctrl.sv
// Bank-queue occupancy counter with waiting-time estimate and error flags.
// Define QUEUE_STATS_EN to add servedCount and peakCount outputs.
module queue_ctrl
    import queue_pkg::*;
#(
    parameter int MAX_PEOPLE  = DEF_MAX_PEOPLE,
    parameter int MAX_TELLERS = DEF_MAX_TELLERS,
    parameter int SERVICE_T   = DEF_SERVICE_T
) (
    input logic   clk,
    input logic   reset,
    queue_if.slave q
);

    localparam int PW = $clog2(MAX_PEOPLE + 1);
    localparam int TW = $clog2(MAX_TELLERS + 1);
    localparam int WW = $clog2(SERVICE_T * MAX_PEOPLE + 1);
    localparam int CW = PW + TW + 4 + $clog2(SERVICE_T + 1);

    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [PW-1:0] P_LAST = PW'(MAX_PEOPLE - 1);

    function automatic logic [WW-1:0] wait_calc(
        input logic [PW-1:0] p,
        input logic [TW-1:0] t
    );
        logic [CW-1:0] num;
        logic [CW-1:0] den;
        logic [WW-1:0] res;
        res = '0;
        if (p != '0) begin
            den = CW'(t);
            num = CW'(SERVICE_T) * (CW'(p) + den - CW'(1));
            res = WW'(num / den);
        end
        return res;
    endfunction

    // async assert, clk-synchronous release
    logic rst_m;
    logic rst_n_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_m   <= 1'b0;
            rst_n_i <= 1'b0;
        end else begin
            rst_m   <= 1'b1;
            rst_n_i <= rst_m;
        end
    end

    logic up_ev;
    logic dn_ev;

    sensor_edge u_up (
        .clk   (clk),
        .rst_n (rst_n_i),
        .din   (q.upSignal),
        .pulse (up_ev)
    );

    sensor_edge u_dn (
        .clk   (clk),
        .rst_n (rst_n_i),
        .din   (q.downSignal),
        .pulse (dn_ev)
    );

    logic arr;
    logic dep;
    logic terr_c;
    logic [TW-1:0] teff;

    assign arr    = up_ev & ~dn_ev;
    assign dep    = dn_ev & ~up_ev;
    assign terr_c = (q.Tcount == '0) ||
                    (int'(q.Tcount) > MAX_TELLERS);
    assign teff   = terr_c ? TW'(1) : q.Tcount;

    q_state_t      state_q;
    q_state_t      state_d;
    logic [PW-1:0] pcount_q;
    logic [PW-1:0] pcount_d;
    logic          ovf_set;
    logic          udf_set;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= EMPTY;
            pcount_q <= '0;
        end else begin
            state_q  <= state_d;
            pcount_q <= pcount_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pcount_d = pcount_q;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (arr) begin
                    pcount_d = pcount_q + 1'b1;
                    state_d  = (MAX_PEOPLE == 1) ? FULL : PARTIAL;
                end else if (dep) begin
                    udf_set = 1'b1;
                end
            end
            PARTIAL: begin
                if (arr) begin
                    pcount_d = pcount_q + 1'b1;
                    state_d  = (pcount_q == P_LAST) ? FULL : PARTIAL;
                end else if (dep) begin
                    pcount_d = pcount_q - 1'b1;
                    state_d  = (pcount_q == P_ONE) ? EMPTY : PARTIAL;
                end
            end
            FULL: begin
                if (arr) begin
                    ovf_set = 1'b1;
                end else if (dep) begin
                    pcount_d = pcount_q - 1'b1;
                    state_d  = (pcount_q == P_ONE) ? EMPTY : PARTIAL;
                end
            end
            default: begin
                state_d  = EMPTY;
                pcount_d = '0;
            end
        endcase
    end

    logic [WW-1:0] wtime_q;
    logic          full_q;
    logic          empty_q;
    logic          ovf_q;
    logic          udf_q;
    logic          terr_q;

    // derived outputs trail pcount/Tcount by one cycle
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wtime_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            wtime_q <= wait_calc(pcount_q, teff);
            full_q  <= (state_q == FULL);
            empty_q <= (state_q == EMPTY);
            ovf_q   <= ovf_q | ovf_set;
            udf_q   <= udf_q | udf_set;
            terr_q  <= terr_c;
        end
    end

    assign q.Pcount    = pcount_q;
    assign q.Wtime     = wtime_q;
    assign q.fullFlag  = full_q;
    assign q.emptyFlag = empty_q;
    assign q.ovfErr    = ovf_q;
    assign q.udfErr    = udf_q;
    assign q.tellerErr = terr_q;

`ifdef QUEUE_STATS_EN
    logic [15:0]   served_q;
    logic [PW-1:0] peak_q;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            served_q <= '0;
            peak_q   <= '0;
        end else begin
            if (dep && state_q != EMPTY) begin
                served_q <= served_q + 16'd1;
            end
            if (pcount_q > peak_q) begin
                peak_q <= pcount_q;
            end
        end
    end

    assign q.servedCount = served_q;
    assign q.peakCount   = peak_q;
`endif

endmodule

// File: tb/tb_queue_ctrl.sv
// Table-driven bench for queue_ctrl with an expected-value scoreboard.
// Hand sequences cover async reset and a sensor held across reset release.
module tb_queue_ctrl;

    localparam int MP = 7;
    localparam int MT = 3;
    localparam int ST = 3;

    typedef struct {
        int op;
        int tc;
        int p;
        int w;
        int full;
        int empty;
        int ovf;
        int udf;
        int terr;
    } vec_t;

    logic clk;
    logic reset;

    queue_if #(
        .MAX_PEOPLE  (MP),
        .MAX_TELLERS (MT),
        .SERVICE_T   (ST)
    ) bus ();

    queue_ctrl #(
        .MAX_PEOPLE  (MP),
        .MAX_TELLERS (MT),
        .SERVICE_T   (ST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t sb[$];
    vec_t tbl[26];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm);
        vec_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, ".Pcount"},    int'(bus.Pcount),    e.p);
            chk({nm, ".Wtime"},     int'(bus.Wtime),     e.w);
            chk({nm, ".fullFlag"},  int'(bus.fullFlag),  e.full);
            chk({nm, ".emptyFlag"}, int'(bus.emptyFlag), e.empty);
            chk({nm, ".ovfErr"},    int'(bus.ovfErr),    e.ovf);
            chk({nm, ".udfErr"},    int'(bus.udfErr),    e.udf);
            chk({nm, ".tellerErr"}, int'(bus.tellerErr), e.terr);
        end
    endtask

    // op bit0 = arrival edge, bit1 = departure edge
    task automatic apply(input vec_t v, input string nm);
        sb.push_back(v);
        bus.Tcount     = 2'(v.tc);
        bus.upSignal   = v.op[0];
        bus.downSignal = v.op[1];
        tick(4);
        bus.upSignal   = 1'b0;
        bus.downSignal = 1'b0;
        tick(6);
        @(negedge clk);
        check_out(nm);
        tick(1);
    endtask

    initial begin
        tbl[0]  = '{1, 2, 1,  3, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 2, 2,  4, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 2, 3,  6, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 2, 4,  7, 0, 0, 0, 0, 0};
        tbl[4]  = '{3, 2, 4,  7, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 4, 12, 0, 0, 0, 0, 1};
        tbl[6]  = '{2, 0, 3,  9, 0, 0, 0, 0, 1};
        tbl[7]  = '{2, 0, 2,  6, 0, 0, 0, 0, 1};
        tbl[8]  = '{0, 3, 2,  4, 0, 0, 0, 0, 0};
        tbl[9]  = '{3, 3, 2,  4, 0, 0, 0, 0, 0};
        tbl[10] = '{2, 1, 1,  3, 0, 0, 0, 0, 0};
        tbl[11] = '{2, 1, 0,  0, 0, 1, 0, 0, 0};
        tbl[12] = '{3, 1, 0,  0, 0, 1, 0, 0, 0};
        tbl[13] = '{2, 1, 0,  0, 0, 1, 0, 1, 0};
        tbl[14] = '{1, 1, 1,  3, 0, 0, 0, 1, 0};
        tbl[15] = '{1, 1, 2,  6, 0, 0, 0, 1, 0};
        tbl[16] = '{1, 1, 3,  9, 0, 0, 0, 1, 0};
        tbl[17] = '{1, 1, 4, 12, 0, 0, 0, 1, 0};
        tbl[18] = '{1, 1, 5, 15, 0, 0, 0, 1, 0};
        tbl[19] = '{1, 1, 6, 18, 0, 0, 0, 1, 0};
        tbl[20] = '{1, 1, 7, 21, 1, 0, 0, 1, 0};
        tbl[21] = '{3, 1, 7, 21, 1, 0, 0, 1, 0};
        tbl[22] = '{1, 1, 7, 21, 1, 0, 1, 1, 0};
        tbl[23] = '{1, 1, 7, 21, 1, 0, 1, 1, 0};
        tbl[24] = '{2, 1, 6, 18, 0, 0, 1, 1, 0};
        tbl[25] = '{2, 1, 5, 15, 0, 0, 1, 1, 0};

        reset          = 1'b1;
        bus.upSignal   = 1'b0;
        bus.downSignal = 1'b0;
        bus.Tcount     = 2'd2;
        tick(3);
        #3;
        reset = 1'b0;
        #1;
        sb.push_back('{0, 2, 0, 0, 0, 1, 0, 0, 0});
        check_out("reset_async");
        tick(3);
        reset = 1'b1;
        tick(10);
        sb.push_back('{0, 2, 0, 0, 0, 1, 0, 0, 0});
        check_out("after_release");

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // arrival edge in flight when reset hits, level held through release
        bus.upSignal = 1'b1;
        tick(2);
        #3;
        reset = 1'b0;
        #1;
        sb.push_back('{0, 1, 0, 0, 0, 1, 0, 0, 0});
        check_out("midq_reset_async");
        tick(3);
        reset = 1'b1;
        tick(12);
        sb.push_back('{0, 1, 0, 0, 0, 1, 0, 0, 0});
        check_out("held_up_release");
        bus.upSignal = 1'b0;
        tick(6);
        sb.push_back('{0, 1, 0, 0, 0, 1, 0, 0, 0});
        check_out("held_up_drop");
        apply('{1, 1, 1, 3, 0, 0, 0, 0, 0}, "post_reset_arrival");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
